// File: rtl/ifu_bpu_dyn.sv
// Branch prediction: 2-bit counter BHT for Bxx, a return address stack for JALR, and next-PC adder operands.
// Latency: predictions are combinational from decode; BHT/RAS updates are visible the cycle after the edge.
// Backpressure: bpu_wait holds the IFU on a JALR rs1 dependency and for the one-cycle regfile read of an xN JALR.
module ifu_bpu_dyn #(
    parameter int PC_SIZE     = 32,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int BHT_IDX_W   = 6,
    parameter int RAS_DEPTH   = 4,
    parameter bit USE_DYN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_SIZE-1:0]     pc,
    input  logic                   dec_i_valid,
    input  logic                   dec_accept,
    input  logic                   dec_jal,
    input  logic                   dec_jalr,
    input  logic                   dec_bxx,
    input  logic [XLEN-1:0]        dec_bjp_imm,
    input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
    input  logic                   oitf_empty,
    input  logic                   ir_empty,
    input  logic                   ir_rs1en,
    input  logic                   ir_valid_clr,
    input  logic                   jalr_rs1idx_cam_irrdidx,
    input  logic [XLEN-1:0]        rf2bpu_x1,
    input  logic [XLEN-1:0]        rf2bpu_rs1,
    input  logic                   upd_valid,
    input  logic [PC_SIZE-1:0]     upd_pc,
    input  logic                   upd_taken,
    input  logic                   ras_clr,
    output logic                   prdt_taken,
    output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
    output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
    output logic                   prdt_ras_hit,
    output logic                   bpu_wait,
    output logic                   bpu2rf_rs1_ena
);
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int PW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW    = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    function automatic logic is_link(input logic [RFIDX_WIDTH-1:0] r);
        return (r == RFIDX_WIDTH'(1)) || (r == RFIDX_WIDTH'(5));
    endfunction

    logic [1:0]         bht [BHT_N];
    logic [PC_SIZE-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]      ras_ptr;
    logic [CW-1:0]      ras_cnt;
    logic               rdrf;

    logic [BHT_IDX_W-1:0] rd_idx, upd_idx;
    logic [1:0]           upd_old, upd_new;
    logic [PW-1:0]        top_ptr, inc_ptr;
    logic [PC_SIZE-1:0]   ret_addr;
    logic rs1_x0, rs1_x1, rs1_lnk, rd_lnk, ras_nz, ras_hit, bxx_taken;
    logic jalr_v, x1_dep, xn_jalr, xn_dep, xn_clr, rdrf_set;
    logic ras_fire, ras_push, ras_pop, ras_repl;
    logic unused_upd_bits;

    assign rd_idx   = pc[BHT_IDX_W+1:2];
    assign upd_idx  = upd_pc[BHT_IDX_W+1:2];
    assign unused_upd_bits = ^{upd_pc[PC_SIZE-1:BHT_IDX_W+2], upd_pc[1:0]};
    assign upd_old  = bht[upd_idx];
    assign upd_new  = upd_taken ? ((upd_old == 2'b11) ? 2'b11 : upd_old + 2'b01)
                                : ((upd_old == 2'b00) ? 2'b00 : upd_old - 2'b01);

    assign top_ptr  = (ras_ptr == '0) ? PTR_MAX : ras_ptr - PW'(1);
    assign inc_ptr  = (ras_ptr == PTR_MAX) ? '0 : ras_ptr + PW'(1);
    assign ret_addr = pc + PC_SIZE'(4);

    assign rs1_x0   = (dec_jalr_rs1idx == '0);
    assign rs1_x1   = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
    assign rs1_lnk  = is_link(dec_jalr_rs1idx);
    assign rd_lnk   = is_link(dec_rdidx);
    assign ras_nz   = (ras_cnt != '0);
    assign ras_hit  = dec_jalr & rs1_lnk & ras_nz;

    assign bxx_taken  = USE_DYN ? bht[rd_idx][1] : dec_bjp_imm[XLEN-1];
    assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bxx_taken);
    assign prdt_ras_hit    = ras_hit;
    assign prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);

    always_comb begin
        prdt_pc_add_op1 = '0;
        if (ras_hit)
            prdt_pc_add_op1 = ras[top_ptr];
        else if (dec_bxx | dec_jal)
            prdt_pc_add_op1 = pc;
        else if (dec_jalr && !rs1_x0)
            prdt_pc_add_op1 = rs1_x1 ? PC_SIZE'(rf2bpu_x1) : PC_SIZE'(rf2bpu_rs1);
    end

    // A RAS hit never needs the register value, so it suppresses every dependency wait.
    assign jalr_v   = dec_i_valid & dec_jalr;
    assign x1_dep   = jalr_v & rs1_x1 & ~ras_hit & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
    assign xn_jalr  = jalr_v & ~rs1_x0 & ~rs1_x1 & ~ras_hit;
    assign xn_dep   = xn_jalr & (~oitf_empty | ~ir_empty);
    assign xn_clr   = xn_dep & oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);
    assign rdrf_set = ~rdrf & xn_jalr & (~xn_dep | xn_clr);

    assign bpu2rf_rs1_ena = rdrf_set;
    assign bpu_wait       = x1_dep | xn_dep | rdrf_set;

    always_comb begin
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ras_repl = 1'b0;
        ras_fire = dec_i_valid & dec_accept;
        if (ras_fire && dec_jal && rd_lnk) begin
            ras_push = 1'b1;
        end else if (ras_fire && dec_jalr) begin
            case ({rd_lnk, rs1_lnk})
                2'b10:   ras_push = 1'b1;
                2'b01:   ras_pop  = ras_nz;
                2'b11: begin
                    // Swapping link registers is a return-then-call: overwrite the top in place.
                    if (dec_rdidx != dec_jalr_rs1idx && ras_nz) ras_repl = 1'b1;
                    else                                        ras_push = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
            ras_ptr <= '0;
            ras_cnt <= '0;
            rdrf    <= 1'b0;
        end else begin
            rdrf <= rdrf_set;
            if (upd_valid) bht[upd_idx] <= upd_new;
            if (ras_clr) begin
                ras_ptr <= '0;
                ras_cnt <= '0;
            end else if (ras_push) begin
                ras_ptr <= inc_ptr;
                if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + CW'(1);
            end else if (ras_pop) begin
                ras_ptr <= top_ptr;
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !ras_clr) begin
            if (ras_push)      ras[ras_ptr] <= ret_addr;
            else if (ras_repl) ras[top_ptr] <= ret_addr;
        end
    end
endmodule

// File: tb/tb_ifu_bpu_dyn.sv
// Randomized and directed bench for ifu_bpu_dyn, checked against a queue/array reference model.
module tb_ifu_bpu_dyn;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        dec_i_valid, dec_accept, dec_jal, dec_jalr, dec_bxx;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
    logic        oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
    logic [31:0] rf2bpu_x1, rf2bpu_rs1;
    logic        upd_valid, upd_taken, ras_clr;
    logic [31:0] upd_pc;

    logic        prdt_taken, prdt_ras_hit, bpu_wait, bpu2rf_rs1_ena;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
    logic        s_taken, s_hit, s_wait, s_ena;
    logic [31:0] s_op1, s_op2;

    ifu_bpu_dyn #(.RAS_DEPTH(DEPTH), .USE_DYN(1'b1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_accept(dec_accept),
        .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
        .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx), .oitf_empty(oitf_empty),
        .ir_empty(ir_empty), .ir_rs1en(ir_rs1en), .ir_valid_clr(ir_valid_clr),
        .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx), .rf2bpu_x1(rf2bpu_x1),
        .rf2bpu_rs1(rf2bpu_rs1), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .ras_clr(ras_clr), .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1),
        .prdt_pc_add_op2(prdt_pc_add_op2), .prdt_ras_hit(prdt_ras_hit), .bpu_wait(bpu_wait),
        .bpu2rf_rs1_ena(bpu2rf_rs1_ena));

    ifu_bpu_dyn #(.RAS_DEPTH(DEPTH), .USE_DYN(1'b0)) dut_s (
        .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_accept(dec_accept),
        .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
        .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx), .oitf_empty(oitf_empty),
        .ir_empty(ir_empty), .ir_rs1en(ir_rs1en), .ir_valid_clr(ir_valid_clr),
        .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx), .rf2bpu_x1(rf2bpu_x1),
        .rf2bpu_rs1(rf2bpu_rs1), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .ras_clr(ras_clr), .prdt_taken(s_taken), .prdt_pc_add_op1(s_op1),
        .prdt_pc_add_op2(s_op2), .prdt_ras_hit(s_hit), .bpu_wait(s_wait),
        .bpu2rf_rs1_ena(s_ena));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state: BHT as plain integers, RAS as a queue with newest entry at the back.
    int          bht_m [64];
    logic [31:0] ras_q [$];
    bit          rd_done;
    bit          e_taken, e_staken, e_hit, e_wait, e_set;
    logic [31:0] e_op1;

    function automatic bit lnk(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

    task automatic model_calc();
        bit jv, x1d, xnj, xnd, xnc;
        e_hit    = dec_jalr && lnk(dec_jalr_rs1idx) && ras_q.size() > 0;
        e_taken  = dec_jal || dec_jalr || (dec_bxx && bht_m[pc[7:2]] >= 2);
        e_staken = dec_jal || dec_jalr || (dec_bxx && dec_bjp_imm[31]);
        if (e_hit)                       e_op1 = ras_q[$];
        else if (dec_bxx || dec_jal)     e_op1 = pc;
        else if (!dec_jalr)              e_op1 = 0;
        else if (dec_jalr_rs1idx == 0)   e_op1 = 0;
        else if (dec_jalr_rs1idx == 1)   e_op1 = rf2bpu_x1;
        else                             e_op1 = rf2bpu_rs1;
        jv  = dec_i_valid && dec_jalr && !e_hit;
        x1d = jv && dec_jalr_rs1idx == 1 && (!oitf_empty || jalr_rs1idx_cam_irrdidx);
        xnj = jv && dec_jalr_rs1idx > 1;
        xnd = xnj && !(oitf_empty && ir_empty);
        xnc = xnd && oitf_empty && !ir_empty && (ir_valid_clr || !ir_rs1en);
        e_set  = !rd_done && xnj && (!xnd || xnc);
        e_wait = x1d || xnd || e_set;
    endtask

    task automatic ras_push(input logic [31:0] a);
        ras_q.push_back(a);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
    endtask

    task automatic model_update();
        logic [31:0] ret;
        bit lrd, lrs;
        model_calc();
        ret = pc + 32'd4;
        lrd = lnk(dec_rdidx);
        lrs = lnk(dec_jalr_rs1idx);
        if (rst) begin
            foreach (bht_m[i]) bht_m[i] = 1;
            ras_q.delete();
            rd_done = 1'b0;
        end else begin
            if (upd_valid) begin
                if (upd_taken && bht_m[upd_pc[7:2]] < 3)       bht_m[upd_pc[7:2]]++;
                else if (!upd_taken && bht_m[upd_pc[7:2]] > 0) bht_m[upd_pc[7:2]]--;
            end
            rd_done = e_set;
            if (ras_clr) ras_q.delete();
            else if (dec_i_valid && dec_accept) begin
                if (dec_jal && lrd) ras_push(ret);
                else if (dec_jalr) begin
                    if (lrd && !lrs) ras_push(ret);
                    else if (!lrd && lrs) begin
                        if (ras_q.size() > 0) void'(ras_q.pop_back());
                    end else if (lrd && lrs) begin
                        if (dec_rdidx != dec_jalr_rs1idx && ras_q.size() > 0) void'(ras_q.pop_back());
                        ras_push(ret);
                    end
                end
            end
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic eval(input string tag);
        #4;
        model_calc();
        chk({tag, ".taken"},  prdt_taken,      e_taken);
        chk({tag, ".staken"}, s_taken,         e_staken);
        chk({tag, ".op1"},    prdt_pc_add_op1, e_op1);
        chk({tag, ".op2"},    prdt_pc_add_op2, dec_bjp_imm);
        chk({tag, ".hit"},    prdt_ras_hit,    e_hit);
        chk({tag, ".wait"},   bpu_wait,        e_wait);
        chk({tag, ".rfena"},  bpu2rf_rs1_ena,  e_set);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        {dec_i_valid, dec_accept, dec_jal, dec_jalr, dec_bxx} = '0;
        dec_bjp_imm = 0; dec_jalr_rs1idx = 0; dec_rdidx = 0; pc = 0;
        {oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx} = '0;
        rf2bpu_x1 = 0; rf2bpu_rs1 = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; ras_clr = 0;
    endtask

    task automatic set_jal(input logic [31:0] p, input logic [4:0] rd, input bit acc);
        idle();
        dec_i_valid = 1; dec_accept = acc; dec_jal = 1; pc = p; dec_rdidx = rd; dec_bjp_imm = 32'h40;
    endtask

    task automatic set_jalr(input logic [4:0] rs1, input logic [4:0] rd, input bit oitf_e, input bit acc);
        idle();
        dec_i_valid = 1; dec_accept = acc; dec_jalr = 1; pc = 32'h800;
        dec_jalr_rs1idx = rs1; dec_rdidx = rd; oitf_empty = oitf_e; ir_empty = 1;
        rf2bpu_x1 = 32'h1111; rf2bpu_rs1 = 32'h5000;
    endtask

    task automatic set_bxx(input logic [31:0] p, input logic [31:0] imm);
        idle();
        dec_i_valid = 1; dec_bxx = 1; pc = p; dec_bjp_imm = imm;
    endtask

    initial begin
        idle();
        rst = 1;
        foreach (bht_m[i]) bht_m[i] = 1;
        rd_done = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        eval("reset");
        chk("reset.outs", {prdt_taken, prdt_pc_add_op1, prdt_ras_hit, bpu_wait, bpu2rf_rs1_ena}, 0);
        tick();

        set_bxx(32'h100, 32'h8);
        eval("bxx_init"); chk("bxx_init_taken", prdt_taken, 0); tick();
        repeat (2) begin idle(); upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; eval("upd"); tick(); end
        set_bxx(32'h100, 32'h4);
        eval("bxx_trained");
        chk("bxx_trained_taken", prdt_taken, 1);
        chk("bxx_trained_op1", prdt_pc_add_op1, 32'h100);
        chk("static_fwd_nt", s_taken, 0);
        tick();
        set_bxx(32'h100, 32'hFFFF_FFFC);
        eval("static_bwd"); chk("static_bwd_taken", s_taken, 1); tick();

        set_bxx(32'h140, 32'h8); upd_valid = 1; upd_pc = 32'h140; upd_taken = 1;
        eval("same_idx"); chk("same_idx_old", prdt_taken, 0); tick();
        set_bxx(32'h140, 32'h8);
        eval("same_idx_next"); chk("same_idx_new", prdt_taken, 1); tick();

        set_jal(32'h200, 5'd1, 1); eval("call"); tick();
        set_jalr(5'd1, 5'd0, 0, 1);
        eval("ret");
        chk("ret_hit", prdt_ras_hit, 1);
        chk("ret_op1", prdt_pc_add_op1, 32'h204);
        chk("ret_wait", bpu_wait, 0);
        tick();
        set_jalr(5'd1, 5'd0, 0, 0);
        eval("ret_empty"); chk("ret_empty_hit", prdt_ras_hit, 0); chk("ret_empty_wait", bpu_wait, 1); tick();

        for (int i = 0; i < 5; i++) begin set_jal(32'h300 + 32'(16 * i), 5'd1, 1); eval("nest_call"); tick(); end
        for (int k = 0; k < 4; k++) begin
            set_jalr(5'd1, 5'd0, 0, 1);
            eval("nest_ret");
            chk("nest_ret_hit", prdt_ras_hit, 1);
            chk("nest_ret_op1", prdt_pc_add_op1, 32'h344 - 32'(16 * k));
            tick();
        end
        set_jalr(5'd1, 5'd0, 0, 0);
        eval("nest_ret5"); chk("nest_ret5_hit", prdt_ras_hit, 0); chk("nest_ret5_wait", bpu_wait, 1); tick();

        set_jalr(5'd7, 5'd0, 1, 0);
        eval("xn0"); chk("xn0_wait", bpu_wait, 1); chk("xn0_ena", bpu2rf_rs1_ena, 1); tick();
        eval("xn1"); chk("xn1_wait", bpu_wait, 0); chk("xn1_ena", bpu2rf_rs1_ena, 0);
        chk("xn1_op1", prdt_pc_add_op1, 32'h5000);
        tick();

        set_jalr(5'd7, 5'd0, 1, 0); eval("rstwait0"); tick();
        rst = 1; eval("rstwait1"); tick();
        rst = 0; eval("rstwait2"); chk("rstwait_reread", bpu2rf_rs1_ena, 1); tick();

        set_jal(32'h400, 5'd1, 1); ras_clr = 1; eval("clr_push"); tick();
        set_jalr(5'd1, 5'd0, 0, 0);
        eval("clr_ret"); chk("clr_ret_hit", prdt_ras_hit, 0); tick();

        for (int n = 0; n < 3000; n++) begin
            int t;
            logic [4:0] regs [5];
            idle();
            regs = '{5'd0, 5'd1, 5'd5, 5'd7, 5'($urandom_range(0, 31))};
            rst = ($urandom_range(0, 299) == 0);
            t = $urandom_range(0, 3);
            dec_bxx = (t == 1); dec_jal = (t == 2); dec_jalr = (t == 3);
            dec_i_valid = ($urandom_range(0, 7) != 0);
            dec_accept = $urandom_range(0, 1);
            pc = ($urandom_range(0, 7) == 0) ? ($urandom() & ~32'h3) : 32'h100 + 32'(4 * $urandom_range(0, 31));
            dec_bjp_imm = $urandom_range(0, 1) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
            dec_jalr_rs1idx = regs[$urandom_range(0, 4)];
            dec_rdidx = regs[$urandom_range(0, 4)];
            {oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx} = 5'($urandom());
            rf2bpu_x1 = $urandom(); rf2bpu_rs1 = $urandom();
            upd_valid = $urandom_range(0, 1);
            upd_pc = 32'h100 + 32'(4 * $urandom_range(0, 31));
            upd_taken = $urandom_range(0, 1);
            ras_clr = ($urandom_range(0, 49) == 0);
            eval($sformatf("rnd%0d", n));
            tick();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
